// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM states, round counts and GF(2^8) arithmetic helpers.
package aes_pkg;

  localparam int unsigned NR_128  = 10;
  localparam int unsigned NR_256  = 14;
  localparam int unsigned BLOCK_W = 128;
  localparam int unsigned ROUND_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    ROUND,
    FINAL,
    DONE
  } aes_state_e;

  // Multiply by x modulo the AES polynomial x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] data,
  output logic [7:0] sub_c
);

  logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;

  // x^254 == x^-1 for x != 0, and maps 0 to 0 as the S-box requires.
  assign x2   = gf_mul(data, data);
  assign x3   = gf_mul(x2, data);
  assign x6   = gf_mul(x3, x3);
  assign x12  = gf_mul(x6, x6);
  assign x15  = gf_mul(x12, x3);
  assign x30  = gf_mul(x15, x15);
  assign x60  = gf_mul(x30, x30);
  assign x120 = gf_mul(x60, x60);
  assign x240 = gf_mul(x120, x120);
  assign x252 = gf_mul(x240, x12);
  assign inv  = gf_mul(x252, x2);

  assign sub_c = inv
               ^ {inv[6:0], inv[7]}
               ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]}
               ^ 8'h63;

endmodule

// File: rtl/aes_encipher.sv
// Iterative AES forward cipher, one round per clock with an external key schedule.
// Define AES_ENCIPHER_AES256_EN to enable 14-round AES-256 selected by keylen.
module aes_encipher
  import aes_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 next,
  input  logic                 keylen,
  output logic [ROUND_W-1:0]   round,
  input  logic [BLOCK_W-1:0]   round_key,
  input  logic [BLOCK_W-1:0]   block,
  output logic [BLOCK_W-1:0]   new_block,
  output logic                 ready
);

  aes_state_e           state_q, state_d;
  logic [BLOCK_W-1:0]   data_d;
  logic [ROUND_W-1:0]   round_d;
  logic                 ready_d;
  logic [ROUND_W-1:0]   last_round_c;
  logic [BLOCK_W-1:0]   sub_bytes_c, shift_rows_c, mix_columns_c;

  // Bytes are column-major: byte index = row + 4*col, byte 0 in bits [127:120].
  function automatic logic [BLOCK_W-1:0] shift_rows(input logic [BLOCK_W-1:0] s);
    logic [BLOCK_W-1:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[127-8*(row+4*c) -: 8] = s[127-8*(row+4*((c+row)%4)) -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [BLOCK_W-1:0] mix_columns(input logic [BLOCK_W-1:0] s);
    logic [BLOCK_W-1:0] r;
    logic [7:0] a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                           xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return r;
  endfunction

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    aes_sbox u_sbox (
      .data  (new_block[127-8*i -: 8]),
      .sub_c (sub_bytes_c[127-8*i -: 8])
    );
  end

  assign shift_rows_c  = shift_rows(sub_bytes_c);
  assign mix_columns_c = mix_columns(shift_rows_c);

`ifdef AES_ENCIPHER_AES256_EN
  logic keylen_q, keylen_d;
  assign last_round_c = keylen_q ? ROUND_W'(NR_256 - 1) : ROUND_W'(NR_128 - 1);
`else
  logic unused_keylen;
  assign unused_keylen = keylen;
  assign last_round_c  = ROUND_W'(NR_128 - 1);
`endif

  // Next-state, datapath and output decode.
  always_comb begin
    state_d  = state_q;
    data_d   = new_block;
    round_d  = round;
`ifdef AES_ENCIPHER_AES256_EN
    keylen_d = keylen_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (next) begin
          state_d  = INIT;
          data_d   = block;
          round_d  = '0;
`ifdef AES_ENCIPHER_AES256_EN
          keylen_d = keylen;
`endif
        end
      end
      INIT: begin
        data_d  = new_block ^ round_key;
        round_d = ROUND_W'(1);
        state_d = ROUND;
      end
      ROUND: begin
        data_d  = mix_columns_c ^ round_key;
        round_d = round + ROUND_W'(1);
        if (round == last_round_c) state_d = FINAL;
      end
      FINAL: begin
        data_d  = shift_rows_c ^ round_key;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      new_block <= '0;
      round     <= '0;
      ready     <= 1'b0;
`ifdef AES_ENCIPHER_AES256_EN
      keylen_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      new_block <= data_d;
      round     <= round_d;
      ready     <= ready_d;
`ifdef AES_ENCIPHER_AES256_EN
      keylen_q  <= keylen_d;
`endif
    end
  end

endmodule

// File: tb/tb_aes_encipher.sv
// Directed-vector bench for aes_encipher with an in-bench key schedule feeding round_key.
module tb_aes_encipher;

  logic         clk = 1'b0;
  logic         rst, next, keylen, ready;
  logic [3:0]   round;
  logic [127:0] round_key, block, new_block;

  always #5 clk = ~clk;

  aes_encipher dut (
    .clk       (clk),
    .rst       (rst),
    .next      (next),
    .keylen    (keylen),
    .round     (round),
    .round_key (round_key),
    .block     (block),
    .new_block (new_block),
    .ready     (ready)
  );

  logic [127:0] rk [0:14];
  always_comb round_key = (round <= 4'd14) ? rk[round] : '0;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [255:0] key;
    int           nk;
    logic         kl;
    logic [127:0] pt;
    logic [127:0] ct;
    int           lat;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xt(t);
    end
    return p;
  endfunction

  // S-box by exhaustive inverse search; only used to build round keys.
  function automatic logic [7:0] sb(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    for (int y = 1; y < 256; y++) if (gm(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
  endfunction

  task automatic expand(input logic [255:0] key, input int nk);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rcon;
    int          nr;
    rcon = 8'h01;
    nr   = nk + 6;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 15; r++)
      rk[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
  endtask

  // Presents a vector with next high; returns after the accepting edge (cycle 1).
  task automatic start(input vec_t v);
    expand(v.key, v.nk);
    block  = v.pt;
    keylen = v.kl;
    next   = 1'b1;
    tick();
    next   = 1'b0;
    block  = ~v.pt;
    keylen = ~v.kl;
  endtask

  task automatic wait_ready(input int c0, output int cyc);
    cyc = c0;
    while (!ready && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  task automatic finish_vec(input string name, input vec_t v, input int c0);
    int cyc;
    wait_ready(c0, cyc);
    check({name, " latency"}, 128'(cyc), 128'(v.lat));
    check({name, " ct"}, new_block, v.ct);
    check({name, " round"}, 128'(round), 128'(v.lat - 2));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vb, vc1;
    int   cyc;

    vecs.push_back('{key: {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, nk: 4, kl: 1'b0,
                     pt: 128'h3243f6a8885a308d313198a2e0370734,
                     ct: 128'h3925841d02dc09fbdc118597196a0b32, lat: 12});
    vecs.push_back('{key: {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, nk: 4, kl: 1'b0,
                     pt: 128'h00112233445566778899aabbccddeeff,
                     ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a, lat: 12});
`ifdef AES_ENCIPHER_AES256_EN
    vecs.push_back('{key: 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                     nk: 8, kl: 1'b1,
                     pt: 128'h00112233445566778899aabbccddeeff,
                     ct: 128'h8ea2b7ca516745bfeafc49904b496089, lat: 16});
`else
    vecs.push_back('{key: {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, nk: 4, kl: 1'b1,
                     pt: 128'h00112233445566778899aabbccddeeff,
                     ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a, lat: 12});
`endif
    vb  = vecs[0];
    vc1 = vecs[1];

    rst = 1'b1; next = 1'b0; keylen = 1'b0; block = '0;
    for (int r = 0; r < 15; r++) rk[r] = '0;
    tick();
    tick();
    check("reset ready", 128'(ready), 128'(0));
    check("reset round", 128'(round), 128'(0));
    check("reset new_block", new_block, 128'h0);

    // rst and next together: reset wins, nothing is loaded.
    next = 1'b1; block = vb.pt;
    tick();
    check("rst+next new_block", new_block, 128'h0);
    rst = 1'b0; next = 1'b0;
    tick();
    check("idle after rst+next", new_block, 128'h0);

    foreach (vecs[i]) begin
      start(vecs[i]);
      finish_vec($sformatf("vec%0d", i), vecs[i], 1);
      tick();
      check($sformatf("vec%0d hold ready", i), 128'(ready), 128'(1));
      check($sformatf("vec%0d hold ct", i), new_block, vecs[i].ct);
    end

    // Round-by-round trace against FIPS-197 C.1.
    start(vc1);
    check("c1 loaded", new_block, vc1.pt);
    tick();
    check("c1 initial ark", new_block, 128'h00102030405060708090a0b0c0d0e0f0);
    tick();
    check("c1 after round1", new_block, 128'h89d810e8855ace682d1843d8cb128fe4);
    check("c1 round idx", 128'(round), 128'(2));
    finish_vec("c1 trace", vc1, 3);

    // Stray next mid-run must be ignored.
    start(vb);
    for (int k = 0; k < 3; k++) tick();
    next = 1'b1;
    tick();
    next = 1'b0;
    check("mid next no restart", 128'(round), 128'(4));
    finish_vec("mid next", vb, 5);

    // Reset mid-run, then a fresh vector.
    start(vb);
    for (int k = 0; k < 5; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort ready", 128'(ready), 128'(0));
    check("abort round", 128'(round), 128'(0));
    check("abort new_block", new_block, 128'h0);
    start(vc1);
    finish_vec("after abort", vc1, 1);

    // Back-to-back with next held high through DONE.
    expand(vb.key, vb.nk);
    block = vb.pt; keylen = 1'b0; next = 1'b1;
    tick();
    wait_ready(1, cyc);
    check("b2b first latency", 128'(cyc), 128'(12));
    check("b2b first ct", new_block, vb.ct);
    expand(vc1.key, vc1.nk);
    block = vc1.pt;
    tick();
    check("b2b ready drop", 128'(ready), 128'(0));
    check("b2b restart load", new_block, vc1.pt);
    wait_ready(1, cyc);
    next = 1'b0;
    check("b2b second latency", 128'(cyc), 128'(12));
    check("b2b second ct", new_block, vc1.ct);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
